mem_ctrl_rr: RTL and testbench

Parametrised byte-serial memory controller for the RV32I out-of-order core. It arbitrates `NPORT` independent requestors onto the single 8-bit RAM/IO bus using round-robin grants, for example instruction fetch/icache refill, load/store unit and a future prefetcher. It serialises variable-length reads and writes, pauses cleanly on `rdy_in`, never over-reads the I/O region, and supports per-port read cancellation on branch flush. It sits between the requestors and the `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins of `cpu`.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/mem_ctrl_rr.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_ctrl_rr.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the byte-serial round-robin memory controller:
// controller state encoding, I/O region decode constants, read/write
// encoding of req_rw, and the request length clamp helper.
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_RD_TAIL = 2'd2,
        ST_WR      = 2'd3
    } state_e;

    // Addresses with addr[17:16] == IO_REGION are side-effecting I/O; the
    // controller never drives an address past the last requested byte.
    localparam logic [1:0] IO_REGION = 2'b11;
    localparam int         IO_LSB    = 16;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Requests longer than the data word are shortened to the data word.
    function automatic int clamp_len(input int len, input int maxb);
        int res;
        if (len > maxb) begin
            res = maxb;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Picks the first requesting port at or
// after ptr (wrapping), returns it one-hot on grant and reports the pointer
// value that follows the winner. The pointer register lives in the parent.
//   req      in  NPORT  eligible requests
//   ptr      in  PTR_W  current round-robin pointer
//   en       in  1      arbitration enable (no grant when low)
//   grant    out NPORT  one-hot winner (all zero when none/disabled)
//   next_ptr out PTR_W  winner+1 mod NPORT (ptr when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NPORT = 2,
    parameter int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic [NPORT-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [NPORT-1:0] grant,
    output logic [PTR_W-1:0] next_ptr
);

    logic [NPORT-1:0] lower_s;
    logic [NPORT-1:0] cand_s;
    logic             found_s;

    // Prefer requests at or above the pointer; wrap to the lowest request
    // only when none exist there.
    always_comb begin
        lower_s  = '0;
        grant    = '0;
        next_ptr = ptr;
        found_s  = 1'b0;
        for (int j = 0; j < NPORT; j++) begin
            lower_s[j] = (j < int'(ptr));
        end
        cand_s = ((req & ~lower_s) != '0) ? (req & ~lower_s) : req;
        for (int j = 0; j < NPORT; j++) begin
            if (en && cand_s[j] && !found_s) begin
                grant[j] = 1'b1;
                found_s  = 1'b1;
                next_ptr = (j == NPORT - 1) ? '0 : PTR_W'(j + 1);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl_rr.sv
// ---------------------------------------------------------------------------
// mem_ctrl_rr
// Byte-serial memory controller arbitrating NPORT requestors onto one 8-bit
// RAM/IO bus. Variable-length reads/writes, pause on rdy_in, per-port read
// flush. Port i of a flattened vector occupies slice i.
//   clk, rst        clock, asynchronous active-high reset
//   rdy_in          bus ready; low pauses the controller
//   req_valid/rw/addr/len/wdata   per-port request (held until req_ready)
//   flush           per-port read cancellation
//   req_ready       one-hot acceptance pulse (combinational)
//   resp_valid      one-hot one-cycle completion pulse
//   resp_data       read data, zero above len bytes; zero for write acks
//   mem_din/mem_dout/mem_a/mem_wr  RAM bus
// ---------------------------------------------------------------------------
module mem_ctrl_rr
    import mem_pkg::*;
#(
    parameter int NPORT  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = $clog2(DATA_W / 8) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy_in,
    input  logic [NPORT-1:0]        req_valid,
    input  logic [NPORT-1:0]        req_rw,
    input  logic [NPORT*ADDR_W-1:0] req_addr,
    input  logic [NPORT*LEN_W-1:0]  req_len,
    input  logic [NPORT*DATA_W-1:0] req_wdata,
    input  logic [NPORT-1:0]        flush,
    output logic [NPORT-1:0]        req_ready,
    output logic [NPORT-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_data,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr
);

    localparam int MAXB  = DATA_W / 8;
    localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NPORT-1:0]    port_oh_q, port_oh_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NPORT-1:0]    resp_pend_q, resp_pend_d;

    logic [NPORT-1:0]    grant_s;
    logic [PTR_W-1:0]    next_ptr_s;
    logic                sel_rw_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [LEN_W-1:0]    sel_len_s;
    logic [LEN_W-1:0]    sel_len_clamp_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [DATA_W-1:0]   cap_data_s;
    logic [ADDR_W-1:0]   addr_sum_s;
    logic                flush_hit_s;
    logic [LEN_W-1:0]    last_s;

    rr_arbiter #(
        .NPORT (NPORT),
        .PTR_W (PTR_W)
    ) u_arb (
        .req      (req_valid & ~flush),
        .ptr      (ptr_q),
        .en       (rdy_in && (state_q == ST_IDLE)),
        .grant    (grant_s),
        .next_ptr (next_ptr_s)
    );

    assign req_ready   = grant_s;
    // A completion that falls in a paused cycle stays pending until resumed.
    assign resp_valid  = resp_pend_q & {NPORT{rdy_in}};
    assign resp_data   = data_q;
    assign flush_hit_s = |(flush & port_oh_q);
    assign last_s      = len_q - LEN_W'(1);
    assign addr_sum_s  = addr_q + ADDR_W'(cnt_q);

    // One-hot mux of the winning port's request payload.
    always_comb begin
        sel_rw_s    = RW_READ;
        sel_addr_s  = '0;
        sel_len_s   = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NPORT; i++) begin
            sel_rw_s    = sel_rw_s | (grant_s[i] & req_rw[i]);
            sel_addr_s  = sel_addr_s | ({ADDR_W{grant_s[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
            sel_len_s   = sel_len_s | ({LEN_W{grant_s[i]}} & req_len[i*LEN_W +: LEN_W]);
            sel_wdata_s = sel_wdata_s | ({DATA_W{grant_s[i]}} & req_wdata[i*DATA_W +: DATA_W]);
        end
        sel_len_clamp_s = LEN_W'(clamp_len(int'(sel_len_s), MAXB));
    end

    // mem_din carries the byte addressed one cycle earlier, i.e. byte cnt-1.
    always_comb begin
        cap_data_s = data_q;
        for (int b = 0; b < MAXB; b++) begin
            cap_data_s[8*b +: 8] = (cnt_q == LEN_W'(b + 1)) ? mem_din : data_q[8*b +: 8];
        end
    end

    // Next-state logic: arbitration, byte sequencing, capture and flush.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        port_oh_d   = port_oh_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        resp_pend_d = rdy_in ? '0 : resp_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s != '0) begin
                    ptr_d     = next_ptr_s;
                    port_oh_d = grant_s;
                    addr_d    = sel_addr_s;
                    len_d     = sel_len_clamp_s;
                    wdata_d   = sel_wdata_s;
                    cnt_d     = '0;
                    data_d    = '0;
                    if (sel_len_clamp_s == '0) begin
                        state_d     = ST_IDLE;
                        resp_pend_d = grant_s;
                    end else if (sel_rw_s == RW_WRITE) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                // Flush is honoured even while paused so a one-cycle flush
                // pulse is never lost.
                if (flush_hit_s) begin
                    state_d = ST_IDLE;
                end else if (rdy_in) begin
                    data_d  = cap_data_s;
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = (cnt_q == last_s) ? ST_RD_TAIL : ST_RD;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_RD_TAIL: begin
                if (flush_hit_s) begin
                    state_d = ST_IDLE;
                end else if (rdy_in) begin
                    data_d      = cap_data_s;
                    state_d     = ST_IDLE;
                    resp_pend_d = port_oh_q;
                end else begin
                    state_d = ST_RD_TAIL;
                end
            end
            ST_WR: begin
                if (rdy_in) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == last_s) begin
                        state_d     = ST_IDLE;
                        resp_pend_d = port_oh_q;
                    end else begin
                        state_d = ST_WR;
                    end
                end else begin
                    state_d = ST_WR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs come only from registers and rdy_in; mem_a holds on pause.
    always_comb begin
        mem_a    = 32'h0000_0000;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        case (state_q)
            ST_RD: begin
                mem_a = 32'(addr_sum_s);
            end
            ST_WR: begin
                mem_a  = 32'(addr_sum_s);
                mem_wr = rdy_in;
                for (int b = 0; b < MAXB; b++) begin
                    mem_dout = mem_dout | ((cnt_q == LEN_W'(b)) ? wdata_q[8*b +: 8] : 8'h00);
                end
            end
            default: begin
                mem_a = 32'h0000_0000;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            port_oh_q   <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            resp_pend_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            port_oh_q   <= port_oh_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            resp_pend_q <= resp_pend_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_rr.sv
module tb_mem_ctrl_rr;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy_in;
    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_rw;
    logic [NP*AW-1:0] req_addr;
    logic [NP*LW-1:0] req_len;
    logic [NP*DW-1:0] req_wdata;
    logic [NP-1:0]    flush;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    resp_valid;
    logic [DW-1:0]    resp_data;
    logic [7:0]       mem_din;
    logic [7:0]       mem_dout;
    logic [31:0]      mem_a;
    logic             mem_wr;

    logic             pre_we;
    logic [17:0]      pre_addr;
    logic [7:0]       pre_data;
    logic [7:0]       ram [0:262143];

    logic [17:0] pl_a [0:7] = '{18'h00100, 18'h00101, 18'h00102, 18'h00103,
                                18'h30000, 18'h00010, 18'h00020, 18'h00030};
    logic [7:0]  pl_d [0:7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hA1, 8'hB2, 8'hC3};

    int checks   = 0;
    int failures = 0;

    mem_ctrl_rr #(
        .NPORT  (NP),
        .ADDR_W (AW),
        .DATA_W (DW),
        .LEN_W  (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy_in     (rdy_in),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .flush      (flush),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_a      (mem_a),
        .mem_wr     (mem_wr)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency; the whole bus stalls while rdy_in is low.
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (rdy_in) begin
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
            mem_din <= ram[mem_a[17:0]];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rdy_in    = 1'b1;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        flush     = '0;
    endtask

    task automatic set_req(input int p, input logic rw, input logic [31:0] a,
                           input logic [2:0] l, input logic [31:0] wd);
        req_valid[p]          = 1'b1;
        req_rw[p]             = rw;
        req_addr[p*AW +: AW]  = a;
        req_len[p*LW +: LW]   = l;
        req_wdata[p*DW +: DW] = wd;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        pre_we = 1'b0;
        clr_in();
        for (int i = 0; i < 8; i++) begin
            step();
            pre_we   = 1'b1;
            pre_addr = pl_a[i];
            pre_data = pl_d[i];
        end
        step();
        pre_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_a, mem_dout, mem_wr} !== 41'd0) begin
            failures++;
            $display("FAIL reset_bus: got a=%h dout=%h wr=%b, expected all 0", mem_a, mem_dout, mem_wr);
        end
        checks++;
        if ({req_ready, resp_valid, resp_data} !== 38'd0) begin
            failures++;
            $display("FAIL reset_resp: got ready=%b rv=%b data=%h, expected all 0", req_ready, resp_valid, resp_data);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_read();
        logic [31:0] ea;
        step();
        set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            failures++;
            $display("FAIL read_grant: got %b, expected 001", req_ready);
        end
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) req_valid[0] = 1'b0;
            @(negedge clk);
            ea = (c <= 4) ? 32'h100 + 32'(c - 1) : 32'h0;
            checks++;
            if ({mem_a, mem_wr} !== {ea, 1'b0}) begin
                failures++;
                $display("FAIL read_addr c%0d: got %h wr=%b, expected %h wr=0", c, mem_a, mem_wr, ea);
            end
            checks++;
            if (resp_valid !== ((c == 6) ? 3'b001 : 3'b000)) begin
                failures++;
                $display("FAIL read_resp c%0d: got %b", c, resp_valid);
            end
            if (c == 6) begin
                checks++;
                if (resp_data !== 32'h44332211) begin
                    failures++;
                    $display("FAIL read_data: got %h, expected 44332211", resp_data);
                end
            end
        end
    endtask

    task automatic test_write();
        step();
        set_req(1, 1'b1, 32'h200, 3'd2, 32'h0000BEEF);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010) begin
            failures++;
            $display("FAIL write_grant: got %b, expected 010", req_ready);
        end
        step();
        req_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_a, mem_dout, mem_wr} !== {32'h200, 8'hEF, 1'b1}) begin
            failures++;
            $display("FAIL write_c1: got a=%h d=%h wr=%b, expected 200 ef 1", mem_a, mem_dout, mem_wr);
        end
        step();
        @(negedge clk);
        checks++;
        if ({mem_a, mem_dout, mem_wr} !== {32'h201, 8'hBE, 1'b1}) begin
            failures++;
            $display("FAIL write_c2: got a=%h d=%h wr=%b, expected 201 be 1", mem_a, mem_dout, mem_wr);
        end
        step();
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_data, mem_wr, mem_a} !== {3'b010, 32'h0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL write_ack: got rv=%b data=%h wr=%b a=%h, expected 010 0 0 0", resp_valid, resp_data, mem_wr, mem_a);
        end
        checks++;
        if ({ram[18'h200], ram[18'h201]} !== 16'hEFBE) begin
            failures++;
            $display("FAIL write_ram: got %h%h, expected efbe", ram[18'h200], ram[18'h201]);
        end
    endtask

    task automatic test_io();
        int hits = 0;
        step();
        set_req(0, 1'b0, 32'h30000, 3'd1, 32'h0);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            failures++;
            $display("FAIL io_grant: got %b, expected 001", req_ready);
        end
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 1) req_valid[0] = 1'b0;
            @(negedge clk);
            if (mem_a == 32'h30000) hits++;
            checks++;
            if (mem_a !== ((c == 1) ? 32'h30000 : 32'h0)) begin
                failures++;
                $display("FAIL io_addr c%0d: got %h", c, mem_a);
            end
        end
        checks++;
        if ({resp_valid, resp_data} !== {3'b001, 32'h0000005A} || hits != 1) begin
            failures++;
            $display("FAIL io_resp: got rv=%b data=%h hits=%0d, expected 001 0000005a 1", resp_valid, resp_data, hits);
        end
    endtask

    task automatic test_clamp();
        step();
        set_req(0, 1'b0, 32'h100, 3'd7, 32'h0);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            failures++;
            $display("FAIL clamp_grant: got %b, expected 001", req_ready);
        end
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) req_valid[0] = 1'b0;
            @(negedge clk);
            if (c == 5) begin
                checks++;
                if (mem_a !== 32'h0) begin
                    failures++;
                    $display("FAIL clamp_overread: got %h, expected 0", mem_a);
                end
            end
        end
        checks++;
        if ({resp_valid, resp_data} !== {3'b001, 32'h44332211}) begin
            failures++;
            $display("FAIL clamp_resp: got rv=%b data=%h, expected 001 44332211", resp_valid, resp_data);
        end
    endtask

    task automatic test_len0_defer();
        step();
        set_req(1, 1'b1, 32'h210, 3'd0, 32'hFF);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010) begin
            failures++;
            $display("FAIL len0_grant: got %b, expected 010", req_ready);
        end
        step();
        req_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ({resp_valid, mem_wr, mem_a} !== {3'b010, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL len0_resp: got rv=%b wr=%b a=%h, expected 010 0 0", resp_valid, mem_wr, mem_a);
        end
        step();
        set_req(0, 1'b1, 32'h210, 3'd1, 32'h77);
        @(negedge clk);
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_a, mem_dout, mem_wr} !== {32'h210, 8'h77, 1'b1}) begin
            failures++;
            $display("FAIL defer_wr: got a=%h d=%h wr=%b, expected 210 77 1", mem_a, mem_dout, mem_wr);
        end
        step();
        rdy_in = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 3'b000) begin
            failures++;
            $display("FAIL defer_paused: got %b, expected 000", resp_valid);
        end
        step();
        rdy_in = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 3'b001 || ram[18'h210] !== 8'h77) begin
            failures++;
            $display("FAIL defer_resume: got rv=%b ram=%h, expected 001 77", resp_valid, ram[18'h210]);
        end
    endtask

    task automatic test_pause();
        logic [31:0] ea;
        step();
        set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) req_valid[0] = 1'b0;
            rdy_in = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            case (c)
                1:       ea = 32'h100;
                2, 3, 4: ea = 32'h101;
                5:       ea = 32'h102;
                6:       ea = 32'h103;
                default: ea = 32'h0;
            endcase
            checks++;
            if ({mem_a, mem_wr} !== {ea, 1'b0}) begin
                failures++;
                $display("FAIL pause_addr c%0d: got %h wr=%b, expected %h", c, mem_a, mem_wr, ea);
            end
            checks++;
            if (resp_valid !== ((c == 8) ? 3'b001 : 3'b000)) begin
                failures++;
                $display("FAIL pause_resp c%0d: got %b", c, resp_valid);
            end
        end
        checks++;
        if (resp_data !== 32'h44332211) begin
            failures++;
            $display("FAIL pause_data: got %h, expected 44332211", resp_data);
        end
    endtask

    task automatic test_flush();
        step();
        set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
        @(negedge clk);
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1) begin
                req_valid[0] = 1'b0;
                set_req(1, 1'b0, 32'h200, 3'd1, 32'h0);
            end
            if (c == 5) req_valid[1] = 1'b0;
            flush = (c == 3) ? 3'b001 : 3'b000;
            @(negedge clk);
            checks++;
            if (req_ready !== ((c == 4) ? 3'b010 : 3'b000)) begin
                failures++;
                $display("FAIL flush_grant c%0d: got %b", c, req_ready);
            end
            checks++;
            if (resp_valid !== ((c == 7) ? 3'b010 : 3'b000)) begin
                failures++;
                $display("FAIL flush_resp c%0d: got %b", c, resp_valid);
            end
            if (c == 4) begin
                checks++;
                if (mem_a !== 32'h0) begin
                    failures++;
                    $display("FAIL flush_idle: got %h, expected 0", mem_a);
                end
            end
        end
        checks++;
        if (resp_data !== 32'h000000EF) begin
            failures++;
            $display("FAIL flush_data: got %h, expected 000000ef", resp_data);
        end
    endtask

    task automatic test_async_reset();
        step();
        set_req(0, 1'b1, 32'h300, 3'd4, 32'hA1B2C3D4);
        @(negedge clk);
        step();
        req_valid[0] = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if ({mem_a, mem_dout, mem_wr} !== {32'h301, 8'hC3, 1'b1}) begin
            failures++;
            $display("FAIL arst_pre: got a=%h d=%h wr=%b, expected 301 c3 1", mem_a, mem_dout, mem_wr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_a, mem_dout, mem_wr, resp_valid, req_ready, resp_data} !== 79'd0) begin
            failures++;
            $display("FAIL arst_now: got a=%h d=%h wr=%b rv=%b", mem_a, mem_dout, mem_wr, resp_valid);
        end
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_a, mem_wr} !== 33'd0) begin
            failures++;
            $display("FAIL arst_idle: got a=%h wr=%b, expected 0", mem_a, mem_wr);
        end
    endtask

    task automatic test_rr();
        logic [2:0] er;
        logic [2:0] ev;
        logic [7:0] ed;
        step();
        set_req(0, 1'b0, 32'h10, 3'd1, 32'h0);
        set_req(1, 1'b0, 32'h20, 3'd1, 32'h0);
        set_req(2, 1'b0, 32'h30, 3'd1, 32'h0);
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) step();
            @(negedge clk);
            er = (c % 3 == 0) ? (3'b001 << ((c / 3) % 3)) : 3'b000;
            ev = (c % 3 == 0 && c > 0) ? (3'b001 << ((c / 3 - 1) % 3)) : 3'b000;
            checks++;
            if (req_ready !== er) begin
                failures++;
                $display("FAIL rr_grant c%0d: got %b, expected %b", c, req_ready, er);
            end
            checks++;
            if (resp_valid !== ev) begin
                failures++;
                $display("FAIL rr_resp c%0d: got %b, expected %b", c, resp_valid, ev);
            end
            if (ev != 3'b000) begin
                ed = (ev == 3'b001) ? 8'hA1 : ((ev == 3'b010) ? 8'hB2 : 8'hC3);
                checks++;
                if (resp_data !== {24'h0, ed}) begin
                    failures++;
                    $display("FAIL rr_data c%0d: got %h, expected %h", c, resp_data, ed);
                end
            end
        end
        step();
        clr_in();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_io();
        test_clamp();
        test_len0_defer();
        test_pause();
        test_flush();
        test_async_reset();
        test_rr();
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
